// File: rtl/multi_driver_arb.sv
// rtl/multi_driver_arb.sv - round-robin arbitrated shared-bus driver with Z turnaround
// Channels request, win an exclusive registered grant, and hand over through a Z gap.
module multi_driver_arb #(
    parameter int WIDTH      = 8,
    parameter int NUM_CH     = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16,
    localparam int ID_W      = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*WIDTH-1:0] datin,
    output logic [NUM_CH-1:0]       gnt,
    output tri   [WIDTH-1:0]        dataout,
    output logic                    bus_valid,
    output logic [ID_W-1:0]         owner_id,
    output logic                    timeout
);

    localparam int         HC_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [3:0] TURN_LAST = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]        turn_cnt_q, turn_cnt_d;
    logic              timeout_q, timeout_d;
    logic [ID_W-1:0]   winner;
    logic              do_arb, rel, preempt;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
        return ID_W'((int'(a) + b) % NUM_CH);
    endfunction

    // Scan downward so the last hit is the nearest request at or above rr_ptr.
    always_comb begin
        winner = rr_ptr_q;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_ptr_q, k)]) winner = wrap_add(rr_ptr_q, k);
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        timeout_d  = 1'b0;
        do_arb     = 1'b0;
        rel        = 1'b0;
        preempt    = 1'b0;
        case (state_q)
            IDLE: do_arb = 1'b1;
            GRANT: begin
                if (hold_cnt_q < HC_W'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + 1'b1;
                rel     = !req[owner_q];
                preempt = (MAX_HOLD > 0) && (hold_cnt_q >= HC_W'(MAX_HOLD - 1))
                          && (|(req & ~gnt_q));
                if (rel || preempt) begin
                    gnt_d     = '0;
                    timeout_d = preempt && !rel;
                    if (TURNAROUND > 0) begin
                        state_d    = TURN;
                        turn_cnt_d = TURN_LAST;
                    end else begin
                        do_arb = 1'b1;
                    end
                end
            end
            TURN: begin
                if (turn_cnt_q == 4'd0) do_arb = 1'b1;
                else turn_cnt_d = turn_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        // A preempted owner still requesting sits last in rotation since rr_ptr is owner+1.
        if (do_arb) begin
            gnt_d = '0;
            if (|req) begin
                state_d       = GRANT;
                gnt_d[winner] = 1'b1;
                owner_d       = winner;
                rr_ptr_d      = wrap_add(winner, 1);
                hold_cnt_d    = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign bus_valid = |gnt_q;
    assign owner_id  = owner_q;
    assign timeout   = timeout_q;
    assign dataout   = (gnt_q != '0) ? datin[int'(owner_q)*WIDTH +: WIDTH] : {WIDTH{1'bz}};

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    assert property (@(posedge clk) disable iff (!rst_n) (state_q != GRANT) |-> (gnt_q == '0));
    assert property (@(posedge clk) disable iff (!rst_n) bus_valid == (|gnt_q));

endmodule
